// File: rtl/sram_wr_ctl_pkg.sv
// Shared definitions for the packet SRAM write controller and its consumers
// (queue manager). Holds the default geometry, the write-FSM state encoding
// and the descriptor layout handed to the queue manager.
package sram_wr_ctl_pkg;

  localparam int DATA_WIDTH    = 256;
  localparam int ADDR_WIDTH    = 10;
  localparam int PORT_ID_WIDTH = 4;
  localparam int MAX_PKT_WORDS = 64;
  localparam int DESC_LEN_W    = ADDR_WIDTH + 1;

  // Write-path FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2,
    ST_DESC = 2'd3
  } wr_state_e;

  // Descriptor as seen by the queue manager.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DESC_LEN_W-1:0]    len;
    logic [PORT_ID_WIDTH-1:0] port;
    logic                     trunc;
  } pkt_desc_t;

endpackage

// File: rtl/sram_wr_ctl.sv
// sram_wr_ctl: writes the arbiter's granted beat stream into the shared
// packet SRAM as a ring buffer and issues one descriptor per packet.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_sop/in_eop/in_port/data_in   beat stream in
//   sram_we/sram_waddr/sram_wdata  registered SRAM write port
//   desc_valid/desc_ready/desc_addr/desc_len/desc_port/desc_trunc
//                                  descriptor handshake to queue manager
//   free_valid/free_len            space returned by the queue manager
//   used_words                     occupied SRAM words
//   err_sop                        one-cycle protocol error pulse
module sram_wr_ctl
  import sram_wr_ctl_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int addr_width    = ADDR_WIDTH,
  parameter int port_id_width = PORT_ID_WIDTH,
  parameter int max_pkt_words = MAX_PKT_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [port_id_width-1:0] in_port,
  input  logic [data_width-1:0]    data_in,
  output logic                     sram_we,
  output logic [addr_width-1:0]    sram_waddr,
  output logic [data_width-1:0]    sram_wdata,
  output logic                     desc_valid,
  input  logic                     desc_ready,
  output logic [addr_width-1:0]    desc_addr,
  output logic [addr_width:0]      desc_len,
  output logic [port_id_width-1:0] desc_port,
  output logic                     desc_trunc,
  input  logic                     free_valid,
  input  logic [addr_width:0]      free_len,
  output logic [addr_width:0]      used_words,
  output logic                     err_sop
);

  localparam int len_w = addr_width + 1;
  localparam int depth = 2 ** addr_width;

  localparam logic [len_w-1:0]      depth_c   = len_w'(depth);
  localparam logic [len_w-1:0]      max_c     = len_w'(max_pkt_words);
  localparam logic [len_w-1:0]      len_one_c = len_w'(1);
  localparam logic [len_w-1:0]      len_zro_c = len_w'(0);
  localparam logic [addr_width-1:0] ptr_one_c = addr_width'(1);

  wr_state_e             state_r;
  logic [addr_width-1:0] wr_ptr_r;
  logic [len_w-1:0]      used_r;
  logic [len_w-1:0]      len_r;

  logic                  space_ok_s;
  logic                  accept_s;
  logic                  write_s;
  logic                  desc_hs_s;
  logic [len_w-1:0]      len_nxt_s;
  logic [len_w-1:0]      free_s;
  logic [len_w-1:0]      wrote_s;
  logic [len_w-1:0]      used_nxt_s;

  // A packet may only start when a worst-case packet fits, so PKT never stalls.
  assign space_ok_s = (depth_c - used_r) >= max_c;
  assign accept_s   = in_valid && in_ready;
  assign desc_hs_s  = desc_valid && desc_ready;

  // Ready per state; in IDLE only a SOP beat lacking headroom is held off.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_sop && !space_ok_s) begin
          in_ready = 1'b0;
        end else begin
          in_ready = 1'b1;
        end
      end
      ST_PKT:  in_ready = 1'b1;
      ST_DROP: in_ready = 1'b1;
      ST_DESC: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Beats reach SRAM on an accepted SOP in IDLE or any accepted beat in PKT.
  always_comb begin
    write_s = 1'b0;
    case (state_r)
      ST_IDLE: write_s = accept_s && in_sop;
      ST_PKT:  write_s = accept_s;
      ST_DROP: write_s = 1'b0;
      ST_DESC: write_s = 1'b0;
      default: write_s = 1'b0;
    endcase
  end

  // Length after this beat: a SOP restarts the count at one.
  always_comb begin
    if (state_r == ST_IDLE) begin
      len_nxt_s = len_one_c;
    end else begin
      len_nxt_s = len_r + len_one_c;
    end
  end

  // Occupancy update: write and free in the same cycle net out exactly.
  always_comb begin
    if (free_valid) begin
      free_s = free_len;
    end else begin
      free_s = len_zro_c;
    end
    if (write_s) begin
      wrote_s = len_one_c;
    end else begin
      wrote_s = len_zro_c;
    end
    used_nxt_s = used_r + wrote_s - free_s;
  end

  // Registered SRAM write port, pointer and occupancy counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_we    <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      wr_ptr_r   <= '0;
      len_r      <= '0;
      used_r     <= '0;
      used_words <= '0;
    end else begin
      sram_we    <= write_s;
      used_r     <= used_nxt_s;
      used_words <= used_nxt_s;
      if (write_s) begin
        sram_waddr <= wr_ptr_r;
        sram_wdata <= data_in;
        // Natural overflow of the pointer gives the ring wrap.
        wr_ptr_r   <= wr_ptr_r + ptr_one_c;
        len_r      <= len_nxt_s;
      end
    end
  end

  // Packet FSM with registered descriptor and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      desc_valid <= 1'b0;
      desc_addr  <= '0;
      desc_len   <= '0;
      desc_port  <= '0;
      desc_trunc <= 1'b0;
      err_sop    <= 1'b0;
    end else begin
      err_sop <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && in_sop) begin
            desc_addr  <= wr_ptr_r;
            desc_port  <= in_port;
            desc_trunc <= 1'b0;
            if (in_eop) begin
              state_r    <= ST_DESC;
              desc_valid <= 1'b1;
              desc_len   <= len_nxt_s;
            end else if (len_nxt_s == max_c) begin
              state_r    <= ST_DROP;
              desc_trunc <= 1'b1;
            end else begin
              state_r <= ST_PKT;
            end
          end else if (accept_s) begin
            // Orphan body beat: discarded, flagged.
            err_sop <= 1'b1;
          end
        end
        ST_PKT: begin
          if (accept_s) begin
            // A stray SOP mid-packet is stored as an ordinary beat.
            err_sop <= in_sop;
            if (in_eop) begin
              state_r    <= ST_DESC;
              desc_valid <= 1'b1;
              desc_len   <= len_nxt_s;
            end else if (len_nxt_s == max_c) begin
              state_r    <= ST_DROP;
              desc_trunc <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (accept_s && in_eop) begin
            state_r    <= ST_DESC;
            desc_valid <= 1'b1;
            desc_len   <= len_r;
          end
        end
        ST_DESC: begin
          if (desc_hs_s) begin
            state_r    <= ST_IDLE;
            desc_valid <= 1'b0;
            desc_trunc <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          desc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wr_ctl.sv
module tb_sram_wr_ctl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_sop, in_eop;
  logic [3:0]   in_port;
  logic [255:0] data_in;
  logic         sram_we;
  logic [9:0]   sram_waddr;
  logic [255:0] sram_wdata;
  logic         desc_valid, desc_ready;
  logic [9:0]   desc_addr;
  logic [10:0]  desc_len;
  logic [3:0]   desc_port;
  logic         desc_trunc;
  logic         free_valid;
  logic [10:0]  free_len;
  logic [10:0]  used_words;
  logic         err_sop;

  int checks = 0;
  int passes = 0;
  int err_cnt = 0;

  logic [9:0]   wa_q[$];
  logic [255:0] wd_q[$];
  logic [9:0]   da_q[$];
  logic [10:0]  dl_q[$];
  logic [3:0]   dp_q[$];
  logic         dt_q[$];

  sram_wr_ctl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_port(in_port), .data_in(data_in),
    .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_port(desc_port), .desc_trunc(desc_trunc),
    .free_valid(free_valid), .free_len(free_len),
    .used_words(used_words), .err_sop(err_sop)
  );

  always #5 clk = ~clk;

  // Collect SRAM writes, descriptor handshakes and error pulses mid-cycle.
  always @(negedge clk) begin
    if (sram_we === 1'b1) begin
      wa_q.push_back(sram_waddr);
      wd_q.push_back(sram_wdata);
    end
    if (err_sop === 1'b1) err_cnt++;
    if (desc_valid === 1'b1 && desc_ready === 1'b1) begin
      da_q.push_back(desc_addr);
      dl_q.push_back(desc_len);
      dp_q.push_back(desc_port);
      dt_q.push_back(desc_trunc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] beat_data(input logic [31:0] seed, input int i);
    logic [31:0] w;
    w = seed + 32'(i);
    return {8{w}};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete();
    da_q.delete(); dl_q.delete(); dp_q.delete(); dt_q.delete();
    err_cnt = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic sop, input logic eop, input logic [3:0] port,
                           input logic [255:0] d);
    int n;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_port = port; data_in = d;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("FAIL beat_accept: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [3:0] port, input logic [31:0] seed);
    for (int i = 0; i < n; i++) send_beat(i == 0, i == n - 1, port, beat_data(seed, i));
  endtask

  task automatic free_words(input logic [10:0] n);
    free_valid = 1'b1; free_len = n;
    @(posedge clk); #1;
    free_valid = 1'b0; free_len = 11'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++; if (sram_we !== 1'b0 || desc_valid !== 1'b0 || err_sop !== 1'b0 || desc_trunc !== 1'b0)
      $display("FAIL reset_ctrl: we=%b dv=%b err=%b tr=%b want 0", sram_we, desc_valid, err_sop, desc_trunc);
    else passes++;
    checks++; if (used_words !== 11'd0 || desc_len !== 11'd0 || desc_addr !== 10'd0 || sram_waddr !== 10'd0)
      $display("FAIL reset_vals: used=%0d len=%0d addr=%0d waddr=%0d want 0", used_words, desc_len, desc_addr, sram_waddr);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passes++;
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_three_beat();
    clear_q();
    send_pkt(3, 4'd2, 32'hA000_0000);
    idle(3);
    checks++; if (wa_q.size() !== 3) $display("FAIL three_nwr: got %0d want 3", wa_q.size()); else passes++;
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 10'(i) || wd_q[i] !== beat_data(32'hA000_0000, i))
        $display("FAIL three_wr%0d: addr %0d data %h want addr %0d", i, wa_q[i], wd_q[i][31:0], i);
      else passes++;
    end
    checks++; if (da_q.size() !== 1) $display("FAIL three_ndesc: got %0d want 1", da_q.size());
    else if (da_q[0] !== 10'd0 || dl_q[0] !== 11'd3 || dp_q[0] !== 4'd2 || dt_q[0] !== 1'b0)
      $display("FAIL three_desc: got {%0d,%0d,%0d,%b} want {0,3,2,0}", da_q[0], dl_q[0], dp_q[0], dt_q[0]);
    else passes++;
    checks++; if (used_words !== 11'd3) $display("FAIL three_used: got %0d want 3", used_words); else passes++;
  endtask

  task automatic test_single_beat();
    clear_q();
    send_beat(1'b1, 1'b1, 4'd5, beat_data(32'h5555_0000, 0));
    idle(3);
    checks++; if (wa_q.size() !== 1 || wa_q[0] !== 10'd3)
      $display("FAIL single_wr: n=%0d want 1 write at 3", wa_q.size());
    else passes++;
    checks++; if (da_q.size() !== 1 || dl_q[0] !== 11'd1 || da_q[0] !== 10'd3 || dp_q[0] !== 4'd5)
      $display("FAIL single_desc: n=%0d want len 1 addr 3 port 5", da_q.size());
    else passes++;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || desc_valid !== 1'b0)
      $display("FAIL single_idle: ready=%b dv=%b want 1,0", in_ready, desc_valid);
    else passes++;
    checks++; if (used_words !== 11'd4) $display("FAIL single_used: got %0d want 4", used_words); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    free_words(11'd4);
    for (int k = 0; k < 15; k++) begin
      send_pkt(64, 4'd1, 32'h1000 + 32'(k * 64));
      idle(2);
      free_words(11'd64);
    end
    clear_q();
    send_pkt(58, 4'd1, 32'h2000);
    idle(2);
    free_words(11'd58);
    checks++; if (wa_q.size() !== 58 || wa_q[wa_q.size()-1] !== 10'd1021)
      $display("FAIL advance_ptr: n=%0d want 58 writes ending at 1021", wa_q.size());
    else passes++;
    checks++; if (used_words !== 11'd0) $display("FAIL advance_used: got %0d want 0", used_words); else passes++;
    clear_q();
    send_pkt(4, 4'd3, 32'h3000);
    idle(3);
    checks++; if (wa_q.size() !== 4) $display("FAIL wrap_nwr: got %0d want 4", wa_q.size());
    else if (wa_q[0] !== 10'd1022 || wa_q[1] !== 10'd1023 || wa_q[2] !== 10'd0 || wa_q[3] !== 10'd1)
      $display("FAIL wrap_addr: got %0d,%0d,%0d,%0d want 1022,1023,0,1", wa_q[0], wa_q[1], wa_q[2], wa_q[3]);
    else passes++;
    checks++; if (da_q.size() !== 1 || da_q[0] !== 10'd1022 || dl_q[0] !== 11'd4 || dp_q[0] !== 4'd3)
      $display("FAIL wrap_desc: n=%0d want addr 1022 len 4 port 3", da_q.size());
    else passes++;
    free_words(11'd4);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 15; k++) send_pkt(64, 4'd4, 32'h4000 + 32'(k * 64));
    send_pkt(63, 4'd4, 32'h4F00);
    idle(3);
    checks++; if (used_words !== 11'd1023) $display("FAIL fill_used: got %0d want 1023", used_words); else passes++;
    clear_q();
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_port = 4'd6;
    data_in = beat_data(32'h6000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) $display("FAIL fill_hold%0d: ready=%b want 0", i, in_ready); else passes++;
    end
    @(posedge clk); #1;
    free_valid = 1'b1; free_len = 11'd64;
    @(posedge clk); #1;
    free_valid = 1'b0; free_len = 11'd0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL fill_release: ready=%b want 1", in_ready); else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    idle(3);
    checks++; if (wa_q.size() !== 1 || wa_q[0] !== 10'd1) $display("FAIL fill_wr: n=%0d want 1 write at 1", wa_q.size());
    else passes++;
    checks++; if (used_words !== 11'd960) $display("FAIL fill_after: got %0d want 960", used_words); else passes++;
    free_words(11'd960);
  endtask

  task automatic test_trunc();
    clear_q();
    send_pkt(70, 4'd7, 32'h7000);
    idle(3);
    checks++; if (wa_q.size() !== 64) $display("FAIL trunc_nwr: got %0d want 64", wa_q.size());
    else if (wa_q[0] !== 10'd2 || wa_q[63] !== 10'd65 || wd_q[63] !== beat_data(32'h7000, 63))
      $display("FAIL trunc_wr: first %0d last %0d want 2,65", wa_q[0], wa_q[63]);
    else passes++;
    checks++; if (da_q.size() !== 1 || dl_q[0] !== 11'd64 || dt_q[0] !== 1'b1 || da_q[0] !== 10'd2)
      $display("FAIL trunc_desc: n=%0d want len 64 trunc 1 addr 2", da_q.size());
    else passes++;
    checks++; if (err_cnt !== 0) $display("FAIL trunc_err: got %0d pulses want 0", err_cnt); else passes++;
    checks++; if (desc_trunc !== 1'b0) $display("FAIL trunc_clear: got %b want 0", desc_trunc); else passes++;
    checks++; if (used_words !== 11'd64) $display("FAIL trunc_used: got %0d want 64", used_words); else passes++;
    free_words(11'd64);
  endtask

  task automatic test_protocol_err();
    clear_q();
    send_beat(1'b0, 1'b0, 4'd8, beat_data(32'h8000, 0));
    idle(3);
    checks++; if (wa_q.size() !== 0) $display("FAIL nonsop_wr: got %0d writes want 0", wa_q.size()); else passes++;
    checks++; if (err_cnt !== 1) $display("FAIL nonsop_err: got %0d pulses want 1", err_cnt); else passes++;
    checks++; if (used_words !== 11'd0) $display("FAIL nonsop_used: got %0d want 0", used_words); else passes++;
    clear_q();
    send_beat(1'b1, 1'b0, 4'd8, beat_data(32'h8100, 0));
    send_beat(1'b1, 1'b1, 4'd8, beat_data(32'h8100, 1));
    idle(3);
    checks++; if (wa_q.size() !== 2 || wa_q[1] !== 10'd67 || err_cnt !== 1)
      $display("FAIL midsop: writes=%0d err=%0d want 2 writes, 1 err", wa_q.size(), err_cnt);
    else passes++;
    checks++; if (da_q.size() !== 1 || dl_q[0] !== 11'd2 || da_q[0] !== 10'd66)
      $display("FAIL midsop_desc: n=%0d want len 2 addr 66", da_q.size());
    else passes++;
    free_words(11'd2);
  endtask

  task automatic test_desc_stall();
    clear_q();
    desc_ready = 1'b0;
    send_pkt(2, 4'd9, 32'h9000);
    in_sop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (desc_valid !== 1'b1 || desc_addr !== 10'd68 || desc_len !== 11'd2 || desc_port !== 4'd9 ||
          desc_trunc !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL stall%0d: dv=%b addr=%0d len=%0d port=%0d ready=%b want 1,68,2,9,0",
                 i, desc_valid, desc_addr, desc_len, desc_port, in_ready);
      else passes++;
    end
    @(posedge clk); #1;
    in_sop = 1'b0;
    desc_ready = 1'b1;
    idle(2);
    checks++; if (da_q.size() !== 1 || desc_valid !== 1'b0)
      $display("FAIL stall_release: hs=%0d dv=%b want 1,0", da_q.size(), desc_valid);
    else passes++;
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_beat(1'b1, 1'b0, 4'd10, beat_data(32'hB000, 0));
    send_beat(1'b0, 1'b0, 4'd10, beat_data(32'hB000, 1));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    checks++; if (da_q.size() !== 0 || desc_valid !== 1'b0)
      $display("FAIL rstmid_desc: n=%0d dv=%b want 0,0", da_q.size(), desc_valid);
    else passes++;
    checks++; if (used_words !== 11'd0) $display("FAIL rstmid_used: got %0d want 0", used_words); else passes++;
    clear_q();
    send_beat(1'b1, 1'b1, 4'd11, beat_data(32'hC000, 0));
    idle(3);
    checks++; if (wa_q.size() !== 1 || wa_q[0] !== 10'd0 || da_q.size() !== 1 || da_q[0] !== 10'd0)
      $display("FAIL rstmid_restart: writes=%0d descs=%0d want 1 each at 0", wa_q.size(), da_q.size());
    else passes++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_port = 4'd0;
    data_in = '0; desc_ready = 1'b1; free_valid = 1'b0; free_len = 11'd0;
    test_reset();
    test_three_beat();
    test_single_beat();
    test_wrap();
    test_fill();
    test_trunc();
    test_protocol_err();
    test_desc_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
